// File: rtl/host_sequencer.sv
// host_sequencer: initiator side of the core's init/req/ack handshake.
// Runs NUM_PROGS programs back to back. The core is held in init first, each program is started
// with a one-cycle DutReq pulse, and the host waits for DutAck. Per-program cycle counts are
// stored in a small result file, and a hung program aborts the batch.
// Optional feature: define HOST_SEQ_INIT_EACH_EN to re-run INIT before every program.
// Without it, INIT runs only before program 0.
module host_sequencer #(
    parameter int unsigned NUM_PROGS      = 3,
    parameter int unsigned INIT_CYCLES    = 2,
    parameter int unsigned CW             = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          DutAck,
    output logic          DutInit,
    output logic          DutReq,
    output logic          Busy,
    output logic          Done,
    output logic          TimedOut,
    output logic [2:0]    ProgIdx,
    input  logic [2:0]    CycRdIdx,
    output logic [CW-1:0] CycRdData
);

    localparam logic [2:0]    LastIdx    = 3'(NUM_PROGS - 1);
    localparam logic [CW-1:0] InitLen    = CW'(INIT_CYCLES);
    localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CntOne     = CW'(1);
    localparam logic [CW-1:0] CntMax     = '1;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StReq,
        StWaitLow,
        StWaitHi,
        StDone
    } seqStateT;

    seqStateT      state;
    logic [CW-1:0] counter;
    // Sized to the full 3-bit index range; entries at NUM_PROGS and above are never written.
    logic [CW-1:0] cycResult [8];

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= StIdle;
            DutInit  <= 1'b1;
            DutReq   <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            TimedOut <= 1'b0;
            ProgIdx  <= '0;
            counter  <= '0;
            for (int i = 0; i < 8; i++) begin
                cycResult[i] <= '0;
            end
        end else begin
            DutReq <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (Go) begin
                        state    <= StInit;
                        DutInit  <= 1'b1;
                        Busy     <= 1'b1;
                        TimedOut <= 1'b0;
                        ProgIdx  <= '0;
                        counter  <= CntOne;
                        for (int i = 0; i < 8; i++) begin
                            cycResult[i] <= '0;
                        end
                    end
                end
                StInit: begin
                    // The counter doubles as the init-length timer here.
                    if (counter >= InitLen) begin
                        state   <= StReq;
                        DutInit <= 1'b0;
                        DutReq  <= 1'b1;
                    end else begin
                        counter <= satInc(counter);
                    end
                end
                StReq: begin
                    counter <= CntOne;
                    state   <= StWaitLow;
                end
                StWaitLow: begin
                    // A stale ack from the previous program is ignored until it drops.
                    if (counter == TimeoutVal) begin
                        cycResult[ProgIdx] <= TimeoutVal;
                        TimedOut           <= 1'b1;
                        Busy               <= 1'b0;
                        Done               <= 1'b1;
                        state              <= StDone;
                    end else begin
                        if (!DutAck) begin
                            state <= StWaitHi;
                        end
                        counter <= satInc(counter);
                    end
                end
                StWaitHi: begin
                    // Completion is tested first, so an ack on the timeout cycle still counts.
                    if (DutAck) begin
                        cycResult[ProgIdx] <= counter;
                        if (ProgIdx == LastIdx) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            ProgIdx <= ProgIdx + 3'd1;
`ifdef HOST_SEQ_INIT_EACH_EN
                            state   <= StInit;
                            DutInit <= 1'b1;
                            counter <= CntOne;
`else
                            state   <= StReq;
                            DutReq  <= 1'b1;
`endif
                        end
                    end else if (counter == TimeoutVal) begin
                        cycResult[ProgIdx] <= TimeoutVal;
                        TimedOut           <= 1'b1;
                        Busy               <= 1'b0;
                        Done               <= 1'b1;
                        state              <= StDone;
                    end else begin
                        counter <= satInc(counter);
                    end
                end
                StDone: begin
                    // Core stays out of init for inspection until Go is released.
                    if (!Go) begin
                        state   <= StIdle;
                        Done    <= 1'b0;
                        DutInit <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Combinational result-file read; out-of-range indices read as zero.
    always_comb begin
        CycRdData = '0;
        if (CycRdIdx <= LastIdx) begin
            CycRdData = cycResult[CycRdIdx];
        end
    end

endmodule
